generic_dual_port_ram_be: RTL and testbench
===========================================

GENERIC_DUAL_PORT_RAM_BE -- requirements
Module: generic_dual_port_ram_be

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32: word width in bits; must be an integer multiple of BYTE_WIDTH.
REQ-002 SHALL have parameter BYTE_WIDTH, default 8: bits per byte lane; LANES = DATA_WIDTH/BYTE_WIDTH.
REQ-003 SHALL have parameter DATA_DEPTH, default 4096: number of words, any value >= 2 (not necessarily a power of 2); AW = $clog2(DATA_DEPTH).
REQ-004 SHALL have parameter OUTPUT_STAGES, default 1: read latency in read_clock cycles, legal values 1 and 2.
REQ-005 SHALL have parameter CLEAR_ON_RESET, default 1: 1 = sweep memory to CLEAR_VALUE after every write-side reset.
REQ-006 SHALL have parameter CLEAR_VALUE, default 0: DATA_WIDTH-bit word written by the clear sweep.
REQ-007 SHALL have port write_clock, input, 1: write-domain clock.
REQ-008 SHALL have port write_reset_n, input, 1: write-domain reset, asynchronous, active-low, clocked by write_clock.
REQ-009 SHALL have port read_clock, input, 1: read-domain clock.
REQ-010 SHALL have port read_reset_n, input, 1: read-domain reset, asynchronous, active-low.
REQ-011 SHALL have port write_enable, input, 1: write request.
REQ-012 SHALL have port write_byte_enable, input, LANES: per-lane write mask; bit k covers data bits [k*BYTE_WIDTH +: BYTE_WIDTH].
REQ-013 SHALL have port write_address, input, AW: write word address.
REQ-014 SHALL have port write_data, input, DATA_WIDTH: write data.
REQ-015 SHALL have port write_ready, output, 1: high when a write is accepted this cycle.
REQ-016 SHALL have port clear_request, input, 1: single-cycle pulse that starts a clear sweep.
REQ-017 SHALL have port clear_busy, output, 1: sweep in progress (write domain).
REQ-018 SHALL have port read_enable, input, 1: read request.
REQ-019 SHALL have port read_address, input, AW: read word address.
REQ-020 SHALL have port read_data, output, DATA_WIDTH: read result.
REQ-021 SHALL have port read_data_valid, output, 1: read_data holds the result of a request.
REQ-022 SHALL have port read_clear_busy, output, 1: clear_busy synchronised into the read domain.

Function
REQ-023 Write-side FSM SHALL have states IDLE and CLEAR; write_ready = (state==IDLE); clear_busy = (state==CLEAR).
REQ-024 In IDLE, write_enable=1 with write_address < DATA_DEPTH SHALL update only the lanes whose write_byte_enable bit is 1 at the next write_clock edge; all other lanes keep their value.
REQ-025 A write with write_address >= DATA_DEPTH or write_byte_enable = 0 SHALL leave memory unchanged.
REQ-026 IDLE -> CLEAR on clear_request=1; the clear counter SHALL start at 0 and write CLEAR_VALUE to one address per cycle; CLEAR -> IDLE after address DATA_DEPTH-1 is written, i.e. exactly DATA_DEPTH cycles of clear_busy.
REQ-027 In CLEAR, write_enable SHALL be ignored (write dropped) and clear_request SHALL be ignored (no restart).
REQ-028 write_enable and clear_request high together in IDLE: the write SHALL be performed, and the sweep SHALL start on the next cycle and overwrite it.
REQ-029 On read_clock, read_enable=1 SHALL capture memory[read_address] into stage 1; with OUTPUT_STAGES=2, stage 1 SHALL advance to stage 2 on the following cycle.
REQ-030 read_data_valid SHALL be read_enable delayed by OUTPUT_STAGES cycles; with read_enable=0 the output stages SHALL hold their previous value.
REQ-031 read_address >= DATA_DEPTH SHALL return all-zero data with valid asserted normally.
REQ-032 A read and a write to the same address within one write_clock period give undefined data; no other corruption is permitted.
REQ-033 read_clear_busy SHALL be clear_busy passed through a 2-flop synchroniser on read_clock.

Reset
REQ-034 write_reset_n low SHALL set state to CLEAR with counter 0 if CLEAR_ON_RESET=1, else to IDLE; a sweep in progress SHALL be aborted and restarted from address 0.
REQ-035 read_reset_n low SHALL clear both output stages and read_data_valid to 0 and preset the synchroniser to CLEAR_ON_RESET.
REQ-036 The memory array SHALL have no reset, so that it infers block RAM.

Structure
REQ-037 Package generic_ram_pkg SHALL hold the write FSM state enum and the legal-value check for OUTPUT_STAGES.
REQ-038 The synchroniser SHALL be the sub-module bit_synchronizer (2 flops, asynchronous reset, reset value set by parameter).

Verification
REQ-039 Reset release, CLEAR_ON_RESET=1, DATA_DEPTH=16 -> clear_busy high for exactly 16 cycles; reads of addresses 0..15 return 0x00000000.
REQ-040 Write 0xAABBCCDD to address 3 with mask 4'b1111, then 0x11223344 with mask 4'b0101 -> read of address 3 returns 0xAA22CC44.
REQ-041 OUTPUT_STAGES=2, read_enable pulse at cycle t -> read_data_valid high at cycle t+2 only; read_data holds its value afterwards.
REQ-042 write_enable held high during a sweep -> no write is accepted; memory is all CLEAR_VALUE when clear_busy falls.
REQ-043 write_reset_n pulsed at sweep address 7 of 16 -> sweep restarts at address 0 and lasts 16 more cycles.
REQ-044 Simultaneous write (address 5, 0xDEADBEEF) and clear_request -> address 5 reads CLEAR_VALUE after the sweep; read_clear_busy follows clear_busy with 2-3 read_clock cycles of delay.

Source files
------------

// File: rtl/generic_ram_pkg.sv
// ============================================================================
// generic_ram_pkg: shared types and parameter checks for generic_dual_port_ram_be
// Revision: 1.0
// ============================================================================
`default_nettype none

package generic_ram_pkg;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } wr_state_t;

    function automatic bit output_stages_legal(input int stages);
        return (stages == 1) || (stages == 2);
    endfunction

endpackage

`default_nettype wire

// File: rtl/bit_synchronizer.sv
// ============================================================================
// bit_synchronizer: two-flop single-bit synchroniser with asynchronous preset value
// Revision: 1.0
// ============================================================================
`default_nettype none

module bit_synchronizer #(
    parameter bit RESET_VALUE = 1'b0
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_d,
    output logic o_q
);

    logic [1:0] r_sync;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sync <= {2{RESET_VALUE}};
        end else begin
            r_sync <= {r_sync[0], i_d};
        end
    end

    assign o_q = r_sync[1];

endmodule

`default_nettype wire

// File: rtl/generic_dual_port_ram_be.sv
// ============================================================================
// generic_dual_port_ram_be: simple dual-clock RAM with byte enables and clear sweep
// Revision: 1.0
// ============================================================================
`default_nettype none

module generic_dual_port_ram_be
    import generic_ram_pkg::*;
#(
    parameter int                   DATA_WIDTH     = 32,
    parameter int                   BYTE_WIDTH     = 8,
    parameter int                   DATA_DEPTH     = 4096,
    parameter int                   OUTPUT_STAGES  = 1,
    parameter bit                   CLEAR_ON_RESET = 1'b1,
    parameter logic [DATA_WIDTH-1:0] CLEAR_VALUE   = '0
) (
    input  logic                               write_clock,
    input  logic                               write_reset_n,
    input  logic                               read_clock,
    input  logic                               read_reset_n,
    input  logic                               write_enable,
    input  logic [DATA_WIDTH/BYTE_WIDTH-1:0]   write_byte_enable,
    input  logic [$clog2(DATA_DEPTH)-1:0]      write_address,
    input  logic [DATA_WIDTH-1:0]              write_data,
    output logic                               write_ready,
    input  logic                               clear_request,
    output logic                               clear_busy,
    input  logic                               read_enable,
    input  logic [$clog2(DATA_DEPTH)-1:0]      read_address,
    output logic [DATA_WIDTH-1:0]              read_data,
    output logic                               read_data_valid,
    output logic                               read_clear_busy
);

    localparam int              c_LANES     = DATA_WIDTH / BYTE_WIDTH;
    localparam int              c_AW        = $clog2(DATA_DEPTH);
    localparam logic [c_AW-1:0] c_LAST_ADDR = c_AW'(DATA_DEPTH - 1);

    if (!output_stages_legal(OUTPUT_STAGES)) begin : g_bad_output_stages
        $error("generic_dual_port_ram_be: OUTPUT_STAGES must be 1 or 2");
    end

    if ((DATA_WIDTH % BYTE_WIDTH) != 0) begin : g_bad_byte_width
        $error("generic_dual_port_ram_be: DATA_WIDTH must be a multiple of BYTE_WIDTH");
    end

    // No reset on the array so it maps onto block RAM.
    logic [DATA_WIDTH-1:0] r_mem [DATA_DEPTH];

    wr_state_t        r_state;
    wr_state_t        w_state_nxt;
    logic [c_AW-1:0]  r_clr_addr;
    logic [c_AW-1:0]  w_clr_addr_nxt;
    logic             w_wr_in_range;
    logic             w_wr_hit;

    assign write_ready   = (r_state == ST_IDLE);
    assign clear_busy    = (r_state == ST_CLEAR);
    assign w_wr_in_range = (32'(write_address) < DATA_DEPTH);
    assign w_wr_hit      = write_reset_n && (r_state == ST_IDLE) && write_enable
                           && w_wr_in_range && (|write_byte_enable);

    always_ff @(posedge write_clock or negedge write_reset_n) begin
        if (!write_reset_n) begin
            r_state    <= CLEAR_ON_RESET ? ST_CLEAR : ST_IDLE;
            r_clr_addr <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_clr_addr <= w_clr_addr_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_clr_addr_nxt = r_clr_addr;
        case (r_state)
            ST_IDLE: begin
                if (clear_request) begin
                    w_state_nxt    = ST_CLEAR;
                    w_clr_addr_nxt = '0;
                end
            end
            ST_CLEAR: begin
                if (r_clr_addr == c_LAST_ADDR) begin
                    w_state_nxt    = ST_IDLE;
                    w_clr_addr_nxt = '0;
                end else begin
                    w_clr_addr_nxt = r_clr_addr + 1'b1;
                end
            end
            default: begin
                w_state_nxt    = ST_IDLE;
                w_clr_addr_nxt = '0;
            end
        endcase
    end

    // The sweep owns the write port; user writes are only taken in IDLE.
    always_ff @(posedge write_clock) begin
        if (r_state == ST_CLEAR) begin
            r_mem[r_clr_addr] <= CLEAR_VALUE;
        end else if (w_wr_hit) begin
            for (int k = 0; k < c_LANES; k++) begin
                if (write_byte_enable[k]) begin
                    r_mem[write_address][k*BYTE_WIDTH +: BYTE_WIDTH] <=
                        write_data[k*BYTE_WIDTH +: BYTE_WIDTH];
                end
            end
        end
    end

    logic [DATA_WIDTH-1:0] w_rd_word;
    logic [DATA_WIDTH-1:0] r_stage1;
    logic                  r_vld1;

    assign w_rd_word = (32'(read_address) < DATA_DEPTH) ? r_mem[read_address] : '0;

    always_ff @(posedge read_clock or negedge read_reset_n) begin
        if (!read_reset_n) begin
            r_stage1 <= '0;
            r_vld1   <= 1'b0;
        end else begin
            r_vld1 <= read_enable;
            if (read_enable) begin
                r_stage1 <= w_rd_word;
            end
        end
    end

    // Stage 2 advances only behind a real request so idle cycles hold the output.
    if (OUTPUT_STAGES == 2) begin : g_two_stages
        logic [DATA_WIDTH-1:0] r_stage2;
        logic                  r_vld2;

        always_ff @(posedge read_clock or negedge read_reset_n) begin
            if (!read_reset_n) begin
                r_stage2 <= '0;
                r_vld2   <= 1'b0;
            end else begin
                r_vld2 <= r_vld1;
                if (r_vld1) begin
                    r_stage2 <= r_stage1;
                end
            end
        end

        assign read_data       = r_stage2;
        assign read_data_valid = r_vld2;
    end else begin : g_one_stage
        assign read_data       = r_stage1;
        assign read_data_valid = r_vld1;
    end

    bit_synchronizer #(
        .RESET_VALUE (CLEAR_ON_RESET)
    ) u_clear_busy_sync (
        .i_clk   (read_clock),
        .i_rst_n (read_reset_n),
        .i_d     (clear_busy),
        .o_q     (read_clear_busy)
    );

endmodule

`default_nettype wire

// File: tb/tb_generic_dual_port_ram_be.sv
// ============================================================================
// tb_generic_dual_port_ram_be: directed self-checking bench for generic_dual_port_ram_be
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_generic_dual_port_ram_be;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic write_reset_n;
    logic read_reset_n;

    // Instance A: depth 16, two output stages, clears to zero on reset.
    logic        a_we, a_cr, a_re;
    logic [3:0]  a_be, a_wa, a_ra;
    logic [31:0] a_wd, a_rd;
    logic        a_wr_rdy, a_busy, a_rv, a_rbusy;

    // Instance B: depth 12, one output stage, no clear on reset, clear value 5A5A5A5A.
    logic        b_we, b_cr, b_re;
    logic [3:0]  b_be, b_wa, b_ra;
    logic [31:0] b_wd, b_rd;
    logic        b_wr_rdy, b_busy, b_rv, b_rbusy;

    generic_dual_port_ram_be #(
        .DATA_WIDTH(32), .BYTE_WIDTH(8), .DATA_DEPTH(16), .OUTPUT_STAGES(2),
        .CLEAR_ON_RESET(1'b1), .CLEAR_VALUE(32'h0)
    ) u_dut_a (
        .write_clock(clk), .write_reset_n(write_reset_n),
        .read_clock(clk), .read_reset_n(read_reset_n),
        .write_enable(a_we), .write_byte_enable(a_be), .write_address(a_wa),
        .write_data(a_wd), .write_ready(a_wr_rdy), .clear_request(a_cr),
        .clear_busy(a_busy), .read_enable(a_re), .read_address(a_ra),
        .read_data(a_rd), .read_data_valid(a_rv), .read_clear_busy(a_rbusy)
    );

    generic_dual_port_ram_be #(
        .DATA_WIDTH(32), .BYTE_WIDTH(8), .DATA_DEPTH(12), .OUTPUT_STAGES(1),
        .CLEAR_ON_RESET(1'b0), .CLEAR_VALUE(32'h5A5A5A5A)
    ) u_dut_b (
        .write_clock(clk), .write_reset_n(write_reset_n),
        .read_clock(clk), .read_reset_n(read_reset_n),
        .write_enable(b_we), .write_byte_enable(b_be), .write_address(b_wa),
        .write_data(b_wd), .write_ready(b_wr_rdy), .clear_request(b_cr),
        .clear_busy(b_busy), .read_enable(b_re), .read_address(b_ra),
        .read_data(b_rd), .read_data_valid(b_rv), .read_clear_busy(b_rbusy)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_bit(input string tag, input logic obs, input logic exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic a_write(input logic [3:0] addr, input logic [31:0] data, input logic [3:0] be);
        a_we = 1'b1; a_wa = addr; a_wd = data; a_be = be;
        @(negedge clk);
        a_we = 1'b0; a_be = 4'h0;
    endtask

    task automatic a_read(input logic [3:0] addr, output logic [31:0] data, output logic vld);
        a_re = 1'b1; a_ra = addr;
        @(negedge clk);
        a_re = 1'b0;
        @(negedge clk);
        data = a_rd; vld = a_rv;
    endtask

    task automatic b_write(input logic [3:0] addr, input logic [31:0] data, input logic [3:0] be);
        b_we = 1'b1; b_wa = addr; b_wd = data; b_be = be;
        @(negedge clk);
        b_we = 1'b0; b_be = 4'h0;
    endtask

    task automatic b_read(input logic [3:0] addr, output logic [31:0] data, output logic vld);
        b_re = 1'b1; b_ra = addr;
        @(negedge clk);
        data = b_rd; vld = b_rv;
        b_re = 1'b0;
    endtask

    // Counts consecutive negedges with clear_busy high, starting at the current one.
    task automatic count_busy(input bit sel_b, output int n);
        n = 0;
        repeat (40) begin
            if (sel_b ? !b_busy : !a_busy) break;
            n++;
            @(negedge clk);
        end
    endtask

    initial begin
        logic [31:0] d;
        logic        v;
        int          n;
        int          rise;

        write_reset_n = 1'b0; read_reset_n = 1'b0;
        a_we = 0; a_cr = 0; a_re = 0; a_be = 0; a_wa = 0; a_ra = 0; a_wd = 0;
        b_we = 0; b_cr = 0; b_re = 0; b_be = 0; b_wa = 0; b_ra = 0; b_wd = 0;
        repeat (3) @(negedge clk);

        check_bit("a_rst_busy", a_busy, 1'b1);
        check_bit("a_rst_ready", a_wr_rdy, 1'b0);
        check_bit("a_rst_valid", a_rv, 1'b0);
        check("a_rst_data", a_rd, 32'h0);
        check_bit("a_rst_rbusy", a_rbusy, 1'b1);
        check_bit("b_rst_busy", b_busy, 1'b0);
        check_bit("b_rst_ready", b_wr_rdy, 1'b1);
        check_bit("b_rst_rbusy", b_rbusy, 1'b0);

        write_reset_n = 1'b1; read_reset_n = 1'b1;
        count_busy(1'b0, n);
        check("a_reset_sweep_len", n, 32'd16);
        check_bit("a_ready_after_sweep", a_wr_rdy, 1'b1);

        for (int i = 0; i < 16; i++) begin
            a_read(4'(i), d, v);
            check("a_rd_after_clear", d, 32'h0);
        end

        a_write(4'd3, 32'hAABBCCDD, 4'b1111);
        a_write(4'd3, 32'h11223344, 4'b0101);
        a_read(4'd3, d, v);
        check("a_byte_merge", d, 32'hAA22CC44);
        check_bit("a_byte_merge_vld", v, 1'b1);
        a_write(4'd2, 32'h12345678, 4'b1000);
        a_write(4'd2, 32'hFFFFFFFF, 4'b0000);
        a_read(4'd2, d, v);
        check("a_lane3_only_mask0", d, 32'h12000000);

        // Two-stage latency and output hold
        a_re = 1'b1; a_ra = 4'd3;
        @(negedge clk);
        a_re = 1'b0;
        check_bit("a_vld_t1", a_rv, 1'b0);
        @(negedge clk);
        check_bit("a_vld_t2", a_rv, 1'b1);
        check("a_data_t2", a_rd, 32'hAA22CC44);
        @(negedge clk);
        check_bit("a_vld_t3", a_rv, 1'b0);
        check("a_data_hold", a_rd, 32'hAA22CC44);

        // Write colliding with clear_request, then writes held through the sweep
        a_write(4'd9, 32'h01020304, 4'b1111);
        a_we = 1'b1; a_wa = 4'd5; a_wd = 32'hDEADBEEF; a_be = 4'hF; a_cr = 1'b1;
        @(negedge clk);
        a_cr = 1'b0; a_wa = 4'd6; a_wd = 32'hFFFFFFFF;
        n = 0; rise = -1;
        repeat (40) begin
            if (!a_busy) break;
            if (rise < 0 && a_rbusy) rise = n;
            if (n == 3) check_bit("a_ready_in_sweep", a_wr_rdy, 1'b0);
            a_cr = (n == 7);
            n++;
            @(negedge clk);
        end
        a_we = 1'b0; a_be = 4'h0; a_cr = 1'b0;
        check("a_user_sweep_len", n, 32'd16);
        check_bit("a_rbusy_rise_delay", (rise >= 2) && (rise <= 3), 1'b1);
        check_bit("a_rbusy_fall_d0", a_rbusy, 1'b1);
        @(negedge clk);
        check_bit("a_rbusy_fall_d1", a_rbusy, 1'b1);
        @(negedge clk);
        check_bit("a_rbusy_fall_d2", a_rbusy, 1'b0);

        a_read(4'd5, d, v); check("a_collide_cleared", d, 32'h0);
        a_read(4'd6, d, v); check("a_sweep_write_dropped", d, 32'h0);
        a_read(4'd9, d, v); check("a_addr9_cleared", d, 32'h0);
        a_read(4'd3, d, v); check("a_addr3_cleared", d, 32'h0);

        // Write-side reset at sweep address 7 restarts the sweep from 0
        a_cr = 1'b1;
        @(negedge clk);
        a_cr = 1'b0;
        repeat (7) @(negedge clk);
        check_bit("a_busy_at_addr7", a_busy, 1'b1);
        write_reset_n = 1'b0;
        @(negedge clk);
        check_bit("a_busy_in_reset", a_busy, 1'b1);
        write_reset_n = 1'b1;
        count_busy(1'b0, n);
        check("a_restart_sweep_len", n, 32'd16);

        // Instance B: non-power-of-two sweep, single stage, out-of-range accesses
        b_cr = 1'b1;
        @(negedge clk);
        b_cr = 1'b0;
        count_busy(1'b1, n);
        check("b_sweep_len", n, 32'd12);
        b_read(4'd0, d, v);  check("b_clear_addr0", d, 32'h5A5A5A5A);
        check_bit("b_vld_1stage", v, 1'b1);
        b_read(4'd11, d, v); check("b_clear_addr11", d, 32'h5A5A5A5A);
        b_write(4'd4, 32'hCAFEF00D, 4'b0011);
        b_read(4'd4, d, v);  check("b_partial_write", d, 32'h5A5AF00D);
        b_write(4'd4, 32'h00000000, 4'b0000);
        b_write(4'd12, 32'h00000000, 4'b1111);
        b_read(4'd4, d, v);  check("b_no_change", d, 32'h5A5AF00D);
        b_read(4'd13, d, v); check("b_oob_read_zero", d, 32'h0);
        check_bit("b_oob_read_vld", v, 1'b1);
        b_read(4'd11, d, v);
        @(negedge clk);
        check_bit("b_vld_drop", b_rv, 1'b0);
        check("b_data_hold", b_rd, 32'h5A5A5A5A);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

endmodule

`default_nettype wire
